// File: rtl/ds1302_write_phy_if.sv
// Request/acknowledge handshake between the RTC controller and the DS1302 write PHY.
interface ds1302_write_phy_if;
  logic       write_en;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic       write_done;
  logic       write_err;
  logic       busy;

  // Requester side (RTC controller).
  modport master (
    output write_en,
    output write_addr,
    output write_data,
    input  write_done,
    input  write_err,
    input  busy
  );

  // Serial engine side.
  modport slave (
    input  write_en,
    input  write_addr,
    input  write_data,
    output write_done,
    output write_err,
    output busy
  );
endinterface

// File: rtl/ds1302_write_phy.sv
// DS1302 3-wire serial write engine: shifts one command byte and one data byte LSB-first
// on CE/SCLK/IO, then pulses write_done after CE drops and holds busy through CE recovery.
// All pad outputs are registered so they are glitch-free.
module ds1302_write_phy #(
  parameter int unsigned HALF_DIV = 100,
  parameter int unsigned CE_SETUP = 400,
  parameter int unsigned CE_HOLD  = 100,
  parameter int unsigned CE_REC   = 400
) (
  input  logic                 clk,
  input  logic                 rst,
  ds1302_write_phy_if.slave    bus,
  output logic                 rtc_ce,
  output logic                 rtc_sclk,
  output logic                 rtc_io_out,
  output logic                 rtc_io_oe
);

  localparam int unsigned Max1   = (HALF_DIV > CE_SETUP) ? HALF_DIV : CE_SETUP;
  localparam int unsigned Max2   = (CE_HOLD > CE_REC) ? CE_HOLD : CE_REC;
  localparam int unsigned MaxCnt = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned CntW   = (MaxCnt < 2) ? 1 : $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] SetupLast = CntW'(CE_SETUP - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_DIV - 1);
  // The DONE cycle is the final hold cycle, so HOLD itself runs one cycle short.
  localparam logic [CntW-1:0] HoldLast  = CntW'(CE_HOLD - 2);
  localparam logic [CntW-1:0] RecLast   = CntW'(CE_REC - 1);
  localparam logic [4:0]      LastBit   = 5'd15;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftLo,
    StShiftHi,
    StHold,
    StDone,
    StRecover
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [15:0]     shift_q, shift_d;
  logic            rej_q, rej_d;
  logic            ce_q, ce_d;
  logic            sclk_q, sclk_d;
  logic            io_q, io_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rej_d   = rej_q;
    ce_d    = ce_q;
    sclk_d  = sclk_q;
    io_d    = io_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.write_en) begin
          // Command bit0 is the read/write select and is forced to write.
          shift_d = {bus.write_data, bus.write_addr & 8'hFE};
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          if (!bus.write_addr[7]) begin
            // Not a valid DS1302 command: report an error without touching the bus.
            rej_d   = 1'b1;
            state_d = StDone;
          end else begin
            rej_d   = 1'b0;
            ce_d    = 1'b1;
            oe_d    = 1'b1;
            io_d    = 1'b0;
            sclk_d  = 1'b0;
            state_d = StSetup;
          end
        end
      end

      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StShiftLo;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShiftLo: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = StShiftHi;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShiftHi: begin
        if (cnt_q == HalfLast) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          bit_d  = bit_q + 1'b1;
          if (bit_q == LastBit) begin
            state_d = (CE_HOLD > 1) ? StHold : StDone;
          end else begin
            // IO only moves on the falling edge so the DS1302 sees it stable at the rise.
            shift_d = shift_q >> 1;
            io_d    = shift_q[1];
            state_d = StShiftLo;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        ce_d    = 1'b0;
        oe_d    = 1'b0;
        io_d    = 1'b0;
        sclk_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = rej_q;
        cnt_d   = '0;
        state_d = StRecover;
      end

      StRecover: begin
        // Recovery is counted from the write_done cycle so CE stays low long enough.
        if (cnt_q == RecLast) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset mid-transfer aborts silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rej_q   <= 1'b0;
      ce_q    <= 1'b0;
      sclk_q  <= 1'b0;
      io_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rej_q   <= rej_d;
      ce_q    <= ce_d;
      sclk_q  <= sclk_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rtc_ce         = ce_q;
  assign rtc_sclk       = sclk_q;
  assign rtc_io_out     = io_q;
  assign rtc_io_oe      = oe_q;
  assign bus.write_done = done_q;
  assign bus.write_err  = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ds1302_write_phy.sv
// Scoreboard bench for ds1302_write_phy with HALF_DIV=2 CE_SETUP=3 CE_HOLD=2 CE_REC=4.
// Stimulus pushes the expected 16-bit wire word per accepted request; a negedge monitor
// reconstructs each transfer from SCLK/IO and checks it when write_done pulses.
module tb_ds1302_write_phy;

  typedef struct {
    logic [15:0] word;
    bit          err;
  } exp_t;

  logic clk;
  logic rst;
  logic rtc_ce, rtc_sclk, rtc_io_out, rtc_io_oe;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  ds1302_write_phy_if bus ();

  ds1302_write_phy #(
    .HALF_DIV (2),
    .CE_SETUP (3),
    .CE_HOLD  (2),
    .CE_REC   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rtc_ce     (rtc_ce),
    .rtc_sclk   (rtc_sclk),
    .rtc_io_out (rtc_io_out),
    .rtc_io_oe  (rtc_io_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Monitor: reconstruct transfers and compare against the scoreboard.
  initial begin : monitor
    int          t0;
    int          nbits;
    int          exp_fall;
    logic [15:0] word;
    logic        busy_p, sclk_p, io_p;
    exp_t        e;
    t0 = 0; nbits = 0; exp_fall = -1; word = '0;
    busy_p = 1'b0; sclk_p = 1'b0; io_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.busy && !busy_p) begin
          t0    = cyc;
          nbits = 0;
          word  = '0;
        end
        if (rtc_sclk && !sclk_p) begin
          // Rise k at T0 + 5 + 4k.
          check("sclk_rise_time", cyc - t0, 5 + 4 * nbits);
          check("ce_at_rise", int'(rtc_ce), 1);
          check("oe_at_rise", int'(rtc_io_oe), 1);
          if (nbits < 16) word[nbits] = rtc_io_out;
          nbits++;
        end
        if (rtc_sclk && sclk_p) check("io_stable_sclk_high", int'(rtc_io_out), int'(io_p));
        if (bus.write_done) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_write_done");
          end else begin
            e = sb.pop_front();
            check("write_err", int'(bus.write_err), int'(e.err));
            check("done_time", cyc - t0, e.err ? 1 : 69);
            check("bit_count", nbits, e.err ? 0 : 16);
            if (!e.err) check("wire_word", int'(word), int'(e.word));
            check("ce_low_at_done", int'(rtc_ce), 0);
            check("oe_low_at_done", int'(rtc_io_oe), 0);
            check("io_low_at_done", int'(rtc_io_out), 0);
            check("busy_at_done", int'(bus.busy), 1);
          end
          exp_fall = cyc + 4;
        end
        if (!bus.busy && busy_p) check("busy_fall_time", cyc, exp_fall);
      end
      busy_p = bus.busy;
      sclk_p = rtc_sclk;
      io_p   = rtc_io_out;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] d,
                      input logic [15:0] exp_word, input bit exp_err, input bit expect_done);
    exp_t e;
    @(negedge clk);
    bus.write_addr = a;
    bus.write_data = d;
    bus.write_en   = 1'b1;
    if (expect_done) begin
      e.word = exp_word;
      e.err  = exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 bus.write_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) fail_now(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ce"}, int'(rtc_ce), 0);
    check({tag, "_sclk"}, int'(rtc_sclk), 0);
    check({tag, "_oe"}, int'(rtc_io_oe), 0);
    check({tag, "_io"}, int'(rtc_io_out), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.write_done), 0);
  endtask

  // Stimulus.
  initial begin : stim
    int   n;
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.write_en   = 1'b0;
    bus.write_addr = 8'h00;
    bus.write_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    // WP unlock: wire word {00, 8E}.
    send(8'h8E, 8'h00, 16'h008E, 1'b0, 1'b1);
    wait_idle("timeout_wp_unlock");

    // Year write: wire word {24, 8C}.
    send(8'h8C, 8'h24, 16'h248C, 1'b0, 1'b1);
    wait_idle("timeout_year");

    // Command bit0 set on input is cleared on the wire.
    send(8'h8D, 8'h55, 16'h558C, 1'b0, 1'b1);
    wait_idle("timeout_bit0");

    // Command without bit7 is rejected.
    send(8'h0E, 8'h77, 16'h0000, 1'b1, 1'b1);
    check("reject_no_ce", int'(rtc_ce), 0);
    wait_idle("timeout_reject");

    // Request while busy is ignored; held request starts a second transfer after recovery.
    @(negedge clk);
    bus.write_addr = 8'h8E;
    bus.write_data = 8'hA5;
    bus.write_en   = 1'b1;
    e.word = 16'hA58E; e.err = 1'b0; sb.push_back(e);
    @(posedge clk);
    #1 bus.write_en = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    bus.write_addr = 8'h80;
    bus.write_data = 8'h3C;
    bus.write_en   = 1'b1;
    e.word = 16'h3C80; e.err = 1'b0; sb.push_back(e);
    n = 0;
    while (!(bus.write_done === 1'b1) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail_now("timeout_first_done");
    n = 0;
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("timeout_first_recover");
    n = 0;
    while (!bus.busy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("timeout_second_accept");
    bus.write_en = 1'b0;
    wait_idle("timeout_second");

    // Reset mid-transfer aborts with no write_done.
    send(8'h8C, 8'h11, 16'h0000, 1'b0, 1'b0);
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_quiet("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (80) @(negedge clk);
    check("abort_no_activity", int'(bus.busy), 0);

    // Normal transfer after the abort.
    send(8'h8E, 8'h00, 16'h008E, 1'b0, 1'b1);
    wait_idle("timeout_after_abort");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
